// File: rtl/maze_render_pkg.sv
// Shared types and constants for the maze render pipeline control path.
package maze_render_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] MODE_MOVE   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  function automatic logic mode_valid(input logic [1:0] m);
    return (m == MODE_MOVE) || (m == MODE_ROTATE);
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster-order x/y counter: clear wins over enable; last_o flags the final pixel of the frame.
module pixel_scan_counter
  import maze_render_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/maze_pixel_sequencer.sv
// Frame sequencer: camera-init handshake, then raster pixel issue through a DEPTH-stage
// valid/coordinate pipeline that freezes whenever the output holds a beat the sink refuses.
module maze_pixel_sequencer
  import maze_render_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int DEPTH    = 4
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               req,
  input  logic [1:0]         req_mode,
  output logic               cam_init_start,
  output logic [1:0]         cam_mode,
  input  logic               cam_init_done,
  input  logic               out_ready,
  output logic [DEPTH-1:0]   stage_valid,
  output logic [DEPTH*XW-1:0] stage_x,
  output logic [DEPTH*YW-1:0] stage_y,
  output logic               out_valid,
  output logic [XW-1:0]      out_x,
  output logic [YW-1:0]      out_y,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [1:0]    pend_mode_q, pend_mode_d;
  logic [1:0]    cam_mode_q, cam_mode_d;
  logic          start_q, start_d;
  logic [15:0]   frame_count_q;
  logic [DEPTH-1:0] vld_q, last_q;
  logic [XW-1:0] x_q [DEPTH];
  logic [YW-1:0] y_q [DEPTH];

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last;
  logic          advance, req_ok, drawing, done;

  assign req_ok  = req && mode_valid(req_mode);
  assign advance = out_ready || !vld_q[DEPTH-1];
  assign drawing = (state_q == ST_DRAW);
  assign done    = (state_q == ST_DRAIN) && vld_q[DEPTH-1] && last_q[DEPTH-1] && out_ready;

  pixel_scan_counter #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .XW(XW), .YW(YW)
  ) u_scan (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .en_i   (drawing && advance),
    .clr_i  (state_q == ST_INIT),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    cam_mode_d  = cam_mode_q;
    start_d     = 1'b0;
    // Requests arriving mid-frame are remembered even while the pipeline is stalled.
    if (req_ok && state_q != ST_IDLE) begin
      pend_d      = 1'b1;
      pend_mode_d = req_mode;
    end
    if (advance) begin
      case (state_q)
        ST_IDLE: if (req_ok) begin
          state_d    = ST_INIT;
          cam_mode_d = req_mode;
          start_d    = 1'b1;
        end
        ST_INIT:  if (cam_init_done) state_d = ST_DRAW;
        ST_DRAW:  if (cnt_last) state_d = ST_DRAIN;
        ST_DRAIN: if (done) begin
          if (pend_q || req_ok) begin
            state_d    = ST_INIT;
            cam_mode_d = req_ok ? req_mode : pend_mode_q;
            pend_d     = 1'b0;
            start_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pend_q        <= 1'b0;
      pend_mode_q   <= 2'b00;
      cam_mode_q    <= 2'b00;
      start_q       <= 1'b0;
      frame_count_q <= 16'd0;
      vld_q         <= '0;
      last_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      cam_mode_q  <= cam_mode_d;
      start_q     <= start_d;
      if (done) frame_count_q <= frame_count_q + 16'd1;
      if (advance) begin
        vld_q[0]  <= drawing;
        last_q[0] <= drawing && cnt_last;
        x_q[0]    <= drawing ? cnt_x : '0;
        y_q[0]    <= drawing ? cnt_y : '0;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i]  <= vld_q[i-1];
          last_q[i] <= last_q[i-1];
          x_q[i]    <= x_q[i-1];
          y_q[i]    <= y_q[i-1];
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stage_x[g*XW +: XW] = x_q[g];
    assign stage_y[g*YW +: YW] = y_q[g];
  end

  assign stage_valid    = vld_q;
  assign out_valid      = vld_q[DEPTH-1];
  assign out_x          = x_q[DEPTH-1];
  assign out_y          = y_q[DEPTH-1];
  assign out_last       = vld_q[DEPTH-1] && last_q[DEPTH-1];
  assign cam_init_start = start_q;
  assign cam_mode       = cam_mode_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = done;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_maze_pixel_sequencer.sv
// Bench for maze_pixel_sequencer: directed frames plus random stall/request traffic checked by a raster scoreboard.
module tb_maze_pixel_sequencer;

  localparam int H = 4, V = 3, D = 4, N = H * V;
  localparam int XW = 10, YW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, req, cam_init_done, out_ready;
  logic [1:0]    req_mode;
  logic          cam_init_start, out_valid, out_last, busy, frame_done;
  logic [1:0]    cam_mode;
  logic [D-1:0]  stage_valid;
  logic [D*XW-1:0] stage_x;
  logic [D*YW-1:0] stage_y;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [15:0]   frame_count;

  maze_pixel_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .DEPTH(D)) dut (
    .clk_in(clk), .reset_n(reset_n), .req(req), .req_mode(req_mode),
    .cam_init_start(cam_init_start), .cam_mode(cam_mode), .cam_init_done(cam_init_done),
    .out_ready(out_ready), .stage_valid(stage_valid), .stage_x(stage_x), .stage_y(stage_y),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  // Degenerate 1x1 frame through a single-stage pipeline.
  logic       b_req, b_init_done, b_out_ready, b_start, b_out_valid, b_out_last, b_busy, b_done;
  logic [1:0] b_req_mode, b_cam_mode;
  logic [0:0] b_stage_valid;
  logic [3:0] b_stage_x, b_stage_y, b_out_x, b_out_y;
  logic [15:0] b_count;

  maze_pixel_sequencer #(.H_ACTIVE(1), .V_ACTIVE(1), .XW(4), .YW(4), .DEPTH(1)) dut_b (
    .clk_in(clk), .reset_n(reset_n), .req(b_req), .req_mode(b_req_mode),
    .cam_init_start(b_start), .cam_mode(b_cam_mode), .cam_init_done(b_init_done),
    .out_ready(b_out_ready), .stage_valid(b_stage_valid), .stage_x(b_stage_x), .stage_y(b_stage_y),
    .out_valid(b_out_valid), .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last),
    .busy(b_busy), .frame_done(b_done), .frame_count(b_count)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: raster index of the next expected beat, request history, frame timing.
  int   cyc = 0;
  logic mon_en = 1'b0;
  int   exp_idx, fc_model, first_c, stalls, last_len;
  logic in_frame, stall_prev, req_since_start, exp_restart, restart_chk;
  logic [1:0] mode_latest;
  logic [D-1:0]    snap_v;
  logic [D*XW-1:0] snap_x;
  logic [D*YW-1:0] snap_y;

  task automatic model_reset();
    exp_idx = 0; fc_model = 0; first_c = 0; stalls = 0; last_len = 0;
    in_frame = 0; stall_prev = 0; req_since_start = 0; exp_restart = 0; restart_chk = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    model_reset();
    mode_latest = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall_prev) begin
          chk("freeze_valid", 64'(stage_valid), 64'(snap_v));
          chk("freeze_x", 64'(stage_x), 64'(snap_x));
          chk("freeze_y", 64'(stage_y), 64'(snap_y));
        end
        if (restart_chk) begin
          chk("restart_start", 64'(cam_init_start), 64'(exp_restart));
          chk("restart_busy", 64'(busy), 64'(exp_restart));
          chk("frame_count", 64'(frame_count), 64'(fc_model));
          restart_chk = 0;
        end
        if (cam_init_start) begin
          chk("start_mode", 64'(cam_mode), 64'(mode_latest));
          req_since_start = 0;
        end
        if (req && (req_mode == 2'b10 || req_mode == 2'b11)) begin
          mode_latest     = req_mode;
          req_since_start = 1;
        end
        if (stage_valid[0] && !in_frame) begin
          in_frame = 1;
          first_c  = cyc;
          stalls   = 0;
        end
        if (in_frame && out_valid && !out_ready) stalls++;
        if (out_valid && out_ready) begin
          chk("out_x", 64'(out_x), 64'(exp_idx % H));
          chk("out_y", 64'(out_y), 64'(exp_idx / H));
          chk("out_last", 64'(out_last), 64'(exp_idx == N - 1));
          chk("frame_done", 64'(frame_done), 64'(exp_idx == N - 1));
          if (exp_idx == N - 1) begin
            last_len = cyc - first_c + 1;
            chk("frame_len", 64'(last_len), 64'(N + D - 1 + stalls));
            fc_model    = (fc_model + 1) % 65536;
            in_frame    = 0;
            exp_idx     = 0;
            exp_restart = req_since_start;
            restart_chk = 1;
          end else begin
            exp_idx++;
          end
        end else if (frame_done) begin
          chk("spurious_done", 64'(frame_done), 64'd0);
        end
        stall_prev = out_valid && !out_ready;
        snap_v = stage_valid;
        snap_x = stage_x;
        snap_y = stage_y;
      end
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic kick(input logic [1:0] m);
    drv(); req = 1'b1; req_mode = m;
    drv(); req = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    smp();
    while (!cam_init_start && k < 20) begin smp(); k++; end
    chk("wait_start", 64'(cam_init_start), 64'd1);
  endtask

  task automatic pulse_init();
    drv(); cam_init_done = 1'b1;
    drv(); cam_init_done = 1'b0;
  endtask

  task automatic wait_stage0();
    int k = 0;
    smp();
    while (!stage_valid[0] && k < 50) begin smp(); k++; end
    chk("wait_stage0", 64'(stage_valid[0]), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    smp();
    while (busy && k < 500) begin smp(); k++; end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_stage_valid"}, 64'(stage_valid), 64'd0);
    chk({t, "_stage_x"}, 64'(stage_x), 64'd0);
    chk({t, "_stage_y"}, 64'(stage_y), 64'd0);
    chk({t, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({t, "_out_last"}, 64'(out_last), 64'd0);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({t, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({t, "_cam_mode"}, 64'(cam_mode), 64'd0);
    chk({t, "_start"}, 64'(cam_init_start), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; req_mode = 2'b00; cam_init_done = 1'b0; out_ready = 1'b1;
    b_req = 1'b0; b_req_mode = 2'b00; b_init_done = 1'b0; b_out_ready = 1'b1;
    repeat (2) drv();
    smp();
    check_zero("reset");
    drv(); reset_n = 1'b1; mon_en = 1'b1;

    // Basic MOVE frame, no stalls.
    kick(2'b10);
    wait_start();
    pulse_init();
    wait_idle();
    chk("t1_count", 64'(frame_count), 64'd1);
    chk("t1_len", 64'(last_len), 64'd15);

    // Five-cycle sink stall mid-frame.
    kick(2'b10);
    wait_start();
    pulse_init();
    begin
      int k = 0;
      smp();
      while (!out_valid && k < 50) begin smp(); k++; end
      chk("t2_wait_valid", 64'(out_valid), 64'd1);
    end
    drv(); out_ready = 1'b0;
    repeat (5) drv();
    out_ready = 1'b1;
    wait_idle();
    chk("t2_len", 64'(last_len), 64'd20);
    chk("t2_count", 64'(frame_count), 64'd2);

    // ROTATE request during a MOVE frame is deferred to the next frame.
    kick(2'b10);
    wait_start();
    pulse_init();
    wait_stage0();
    drv(); req = 1'b1; req_mode = 2'b11;
    drv(); req = 1'b0;
    smp();
    chk("t3_mode_hold", 64'(cam_mode), 64'd2);
    begin
      int k = 0;
      while (!frame_done && k < 100) begin smp(); k++; end
      chk("t3_done", 64'(frame_done), 64'd1);
      chk("t3_mode_at_done", 64'(cam_mode), 64'd2);
    end
    smp();
    chk("t3_restart", 64'(cam_init_start), 64'd1);
    chk("t3_new_mode", 64'(cam_mode), 64'd3);
    pulse_init();
    wait_idle();
    chk("t3_count", 64'(frame_count), 64'd4);

    // Invalid mode and stray init_done while idle.
    drv(); req = 1'b1; req_mode = 2'b01;
    drv(); req = 1'b0; cam_init_done = 1'b1;
    drv(); cam_init_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_start", 64'(cam_init_start), 64'd0);
    end

    // Reset pulse in the middle of DRAW aborts the frame.
    kick(2'b11);
    wait_start();
    pulse_init();
    wait_stage0();
    drv(); mon_en = 1'b0; reset_n = 1'b0;
    drv(); reset_n = 1'b1;
    smp();
    check_zero("t5");
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t5_no_done", 64'(frame_done), 64'd0);
      chk("t5_idle", 64'(busy), 64'd0);
    end
    model_reset();
    mon_en = 1'b1;

    // Random sink backpressure, init delays and request traffic.
    for (int c = 0; c < 800; c++) begin
      drv();
      out_ready     = ($urandom_range(0, 3) != 0);
      cam_init_done = ($urandom_range(0, 2) == 0);
      req           = ($urandom_range(0, 24) == 0);
      req_mode      = 2'($urandom_range(0, 3));
    end
    drv(); req = 1'b0; out_ready = 1'b1; cam_init_done = 1'b1;
    wait_idle();
    chk("rand_count", 64'(frame_count), 64'(fc_model));
    drv(); cam_init_done = 1'b0;

    // Single-pixel frame, single-stage pipeline.
    drv(); b_req = 1'b1; b_req_mode = 2'b11;
    drv(); b_req = 1'b0; b_init_done = 1'b1;
    begin
      int k = 0;
      smp();
      while (!b_out_valid && k < 20) begin smp(); k++; end
      chk("b_valid", 64'(b_out_valid), 64'd1);
      chk("b_last", 64'(b_out_last), 64'd1);
      chk("b_done", 64'(b_done), 64'd1);
      chk("b_xy", 64'({b_out_x, b_out_y}), 64'd0);
      chk("b_mode", 64'(b_cam_mode), 64'd3);
    end
    smp();
    chk("b_count", 64'(b_count), 64'd1);
    chk("b_idle", 64'(b_busy), 64'd0);
    chk("b_single", 64'(b_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
